// File: rtl/mem_pkg.sv
// Shared memory-system definitions: region map, region classification and default word width.
package mem_pkg;

  localparam int DEF_WORD_SIZE = 32;

  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_MMIO, REG_NONE} region_t;

  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_LIMIT  = 32'h0000_FFFF;
  localparam logic [31:0] RAM_BASE   = 32'h1000_0000;
  localparam logic [31:0] RAM_LIMIT  = 32'h1000_FFFF;
  localparam logic [31:0] MMIO_BASE  = 32'h2000_0000;
  localparam logic [31:0] MMIO_LIMIT = 32'h2000_0FFF;

  // Offset form keeps the test free of always-true compares for a zero base.
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (a - base) <= (limit - base);
  endfunction

  function automatic region_t region_of(input logic [31:0] a);
    if (in_range(a, ROM_BASE, ROM_LIMIT))        return REG_ROM;
    else if (in_range(a, RAM_BASE, RAM_LIMIT))   return REG_RAM;
    else if (in_range(a, MMIO_BASE, MMIO_LIMIT)) return REG_MMIO;
    else                                         return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-region decoder: flags cacheable and mapped addresses.
module mem_region_decode
  import mem_pkg::*;
(
  input  logic [31:0] addr,
  output logic        cacheable,
  output logic        valid_addr
);

  region_t region;

  always_comb region = region_of(addr);

  assign cacheable  = (region == REG_ROM) || (region == REG_RAM);
  assign valid_addr = (region != REG_NONE);

endmodule

// File: rtl/wt_cache_region.sv
// Direct-mapped, write-through, one-word-per-line cache fronted by an address-region decoder.
module wt_cache_region
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_LINES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic                 re,
  input  logic                 wr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 cache_miss_stall,
  output logic                 cacheable,
  output logic                 valid_addr,
  output logic [31:0]          ext_addr,
  output logic [WORD_SIZE-1:0] ext_data_out,
  input  logic [WORD_SIZE-1:0] ext_data_in,
  output logic                 ext_re,
  output logic                 ext_wr,
  input  logic                 ext_ack
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [WORD_SIZE-1:0] data_arr [NUM_LINES];
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] line_valid;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag_in;
  logic                 hit;
  logic                 rd_only;
  logic                 wr_req;
  logic                 rd_req;
  logic                 fill;
  logic [WORD_SIZE-1:0] fill_data;
  logic                 unused_bits;

  mem_region_decode u_decode (
    .addr       (addr),
    .cacheable  (cacheable),
    .valid_addr (valid_addr)
  );

  assign idx         = addr[IDX_W+1:2];
  assign tag_in      = addr[31:IDX_W+2];
  assign unused_bits = ^addr[1:0];

  assign hit     = line_valid[idx] && (tag_arr[idx] == tag_in);
  assign rd_only = cacheable && re && !wr;

  // Raw requests drive state; the strobes are additionally squashed while in reset.
  assign wr_req    = cacheable && wr;
  assign rd_req    = rd_only && !hit;
  assign fill      = (wr_req || rd_req) && ext_ack;
  assign fill_data = wr ? data_in : ext_data_in;

  assign ext_wr           = rst && wr_req;
  assign ext_re           = rst && rd_req;
  assign ext_addr         = {addr[31:2], 2'b00};
  assign ext_data_out     = data_in;
  assign cache_miss_stall = (ext_wr || ext_re) && !ext_ack;

  // Hits come straight from the array; a miss forwards bus data during its ack cycle.
  always_comb begin
    data_out = '0;
    if (rst && rd_only) begin
      if (hit)          data_out = data_arr[idx];
      else if (ext_ack) data_out = ext_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      line_valid <= '0;
    else if (fill) line_valid[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[idx] <= fill_data;
      tag_arr[idx]  <= tag_in;
    end
  end

endmodule

// File: tb/tb_wt_cache_region.sv
// Self-checking bench for wt_cache_region: directed scenarios plus randomized traffic vs a line model.
module tb_wt_cache_region;

  localparam int NL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        cache_miss_stall;
  logic        cacheable;
  logic        valid_addr;
  logic [31:0] ext_addr;
  logic [31:0] ext_data_out;
  logic [31:0] ext_data_in = '0;
  logic        ext_re;
  logic        ext_wr;
  logic        ext_ack = 1'b0;

  int checks = 0;
  int passed = 0;

  // Model: each line remembers the full word address it holds and its data.
  bit          m_valid [NL];
  logic [29:0] m_waddr [NL];
  logic [31:0] m_data  [NL];

  wt_cache_region #(.WORD_SIZE(32), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .wr(wr), .data_in(data_in),
    .data_out(data_out), .cache_miss_stall(cache_miss_stall), .cacheable(cacheable),
    .valid_addr(valid_addr), .ext_addr(ext_addr), .ext_data_out(ext_data_out),
    .ext_data_in(ext_data_in), .ext_re(ext_re), .ext_wr(ext_wr), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NL);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_waddr[m_idx(a)] == a[31:2]);
  endfunction

  function automatic void m_fill(input logic [31:0] a, input logic [31:0] d);
    m_valid[m_idx(a)] = 1'b1;
    m_waddr[m_idx(a)] = a[31:2];
    m_data[m_idx(a)]  = d;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic bit exp_cacheable(input logic [31:0] a);
    return (a <= 32'h0000_FFFF) || (a >= 32'h1000_0000 && a <= 32'h1000_FFFF);
  endfunction

  function automatic bit exp_valid(input logic [31:0] a);
    return exp_cacheable(a) || (a >= 32'h2000_0000 && a <= 32'h2000_0FFF);
  endfunction

  // Called at posedge+1; leaves time at posedge+3 so outputs can be sampled.
  task automatic drive(input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic ack, input logic [31:0] xd);
    addr = a; re = r; wr = w; data_in = d; ext_ack = ack; ext_data_in = xd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    drive(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b0) $display("FAIL reset_ext_re: got %b expected 0", ext_re); else passed++;
    checks++; if (cache_miss_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", cache_miss_stall); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else passed++;
    drive(32'h1000_0000, 1'b0, 1'b1, 32'h55, 1'b1, 32'h0);
    checks++; if (ext_wr !== 1'b0) $display("FAIL reset_ext_wr: got %b expected 0", ext_wr); else passed++;
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    m_clear();
  endtask

  task automatic test_read_miss_fill();
    drive(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b1) $display("FAIL miss_ext_re: got %b expected 1", ext_re); else passed++;
    checks++; if (cache_miss_stall !== 1'b1) $display("FAIL miss_stall: got %b expected 1", cache_miss_stall); else passed++;
    checks++; if (ext_addr !== 32'h10) $display("FAIL miss_ext_addr: got %h expected 00000010", ext_addr); else passed++;
    tick();
    checks++; if (cache_miss_stall !== 1'b1) $display("FAIL miss_hold_stall: got %b expected 1", cache_miss_stall); else passed++;
    drive(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL miss_fwd_data: got %h expected deadbeef", data_out); else passed++;
    checks++; if (cache_miss_stall !== 1'b0) $display("FAIL miss_ack_stall: got %b expected 0", cache_miss_stall); else passed++;
    m_fill(32'h10, 32'hDEAD_BEEF);
    tick();
    drive(32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b0) $display("FAIL hit_ext_re: got %b expected 0", ext_re); else passed++;
    checks++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL hit_data: got %h expected deadbeef", data_out); else passed++;
    tick();
  endtask

  task automatic test_write_through();
    drive(32'h1000_0004, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    checks++; if (ext_wr !== 1'b1) $display("FAIL wr_ext_wr: got %b expected 1", ext_wr); else passed++;
    checks++; if (ext_data_out !== 32'h1234_5678) $display("FAIL wr_ext_data: got %h expected 12345678", ext_data_out); else passed++;
    checks++; if (cache_miss_stall !== 1'b1) $display("FAIL wr_stall: got %b expected 1", cache_miss_stall); else passed++;
    tick();
    drive(32'h1000_0004, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0);
    checks++; if (cache_miss_stall !== 1'b0) $display("FAIL wr_ack_stall: got %b expected 0", cache_miss_stall); else passed++;
    m_fill(32'h1000_0004, 32'h1234_5678);
    tick();
    drive(32'h1000_0004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if ({ext_re, ext_wr} !== 2'b00) $display("FAIL wr_hit_bus: got %b expected 00", {ext_re, ext_wr}); else passed++;
    checks++; if (data_out !== 32'h1234_5678) $display("FAIL wr_hit_data: got %h expected 12345678", data_out); else passed++;
    tick();
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    seq[0] = 32'h0000_0000; seq[1] = 32'h0000_0100; seq[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      drive(seq[k], 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (ext_re !== !m_hit(seq[k]))
        $display("FAIL conflict_miss_%0d: got ext_re=%b expected %b", k, ext_re, !m_hit(seq[k]));
      else passed++;
      drive(seq[k], 1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + 32'(k));
      if (!m_hit(seq[k])) m_fill(seq[k], 32'hA000_0000 + 32'(k));
      tick();
    end
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_region();
    logic [31:0] edges [12];
    logic [31:0] a;
    drive(32'h2000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({cacheable, valid_addr, cache_miss_stall, ext_re} !== 4'b0100)
      $display("FAIL mmio_flags: got %b expected 0100", {cacheable, valid_addr, cache_miss_stall, ext_re});
    else passed++;
    drive(32'h3000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (valid_addr !== 1'b0) $display("FAIL unmapped_valid: got %b expected 0", valid_addr); else passed++;
    edges = '{32'h0, 32'h0000_FFFF, 32'h0001_0000, 32'h0FFF_FFFF, 32'h1000_0000, 32'h1000_FFFF,
              32'h1001_0000, 32'h1FFF_FFFF, 32'h2000_0000, 32'h2000_0FFF, 32'h2000_1000, 32'hFFFF_FFFF};
    for (int k = 0; k < 36; k++) begin
      a = (k < 12) ? edges[k] : edges[$urandom_range(0, 11)] + 32'($urandom_range(0, 8)) - 32'd4;
      drive(a, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if ({cacheable, valid_addr} !== {exp_cacheable(a), exp_valid(a)})
        $display("FAIL region_%h: got %b expected %b", a, {cacheable, valid_addr}, {exp_cacheable(a), exp_valid(a)});
      else passed++;
    end
    drive(32'h2000_0010, 1'b0, 1'b1, 32'h77, 1'b1, 32'h0);
    checks++;
    if ({ext_wr, cache_miss_stall, data_out} !== 34'h0)
      $display("FAIL mmio_inert: got %b/%b/%h expected 0/0/0", ext_wr, cache_miss_stall, data_out);
    else passed++;
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_spurious_ack();
    drive(32'h1000_0100, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0BAD);
    tick();
    drive(32'h1000_0100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b1) $display("FAIL spurious_ack_fill: got ext_re=%b expected 1", ext_re); else passed++;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_miss();
    drive(32'h1000_0200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b1) $display("FAIL rmm_pre_ext_re: got %b expected 1", ext_re); else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({ext_re, cache_miss_stall} !== 2'b00)
      $display("FAIL rmm_drop: got %b expected 00", {ext_re, cache_miss_stall});
    else passed++;
    m_clear();
    tick();
    rst = 1'b1;
    tick();
    drive(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b1) $display("FAIL rmm_lost_10: got ext_re=%b expected 1", ext_re); else passed++;
    drive(32'h1000_0004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (ext_re !== 1'b1) $display("FAIL rmm_lost_1004: got ext_re=%b expected 1", ext_re); else passed++;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_rw_priority();
    drive(32'h1000_0008, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
    checks++;
    if ({ext_wr, ext_re} !== 2'b10) $display("FAIL rw_strobes: got %b expected 10", {ext_wr, ext_re});
    else passed++;
    checks++; if (ext_data_out !== 32'hCAFE_F00D) $display("FAIL rw_data: got %h expected cafef00d", ext_data_out); else passed++;
    drive(32'h1000_0008, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h1111_1111);
    m_fill(32'h1000_0008, 32'hCAFE_F00D);
    tick();
    drive(32'h1000_0008, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (data_out !== 32'hCAFE_F00D) $display("FAIL rw_readback: got %h expected cafef00d", data_out); else passed++;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'h1000_0000;
    return base | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [31:0] a, d, xd, exp_rd;
    bit          w, req;
    for (int n = 0; n < 150; n++) begin
      a = rand_addr();
      w = ($urandom_range(0, 9) < 4);
      d = $urandom;
      drive(a, 1'b1, w, d, 1'b0, 32'h0);
      req = w || !m_hit(a);
      checks++;
      if ({ext_re, ext_wr, cache_miss_stall} !== {!w && req, w, req})
        $display("FAIL rnd_ctl_%0d: got %b expected %b", n, {ext_re, ext_wr, cache_miss_stall}, {!w && req, w, req});
      else passed++;
      if (!req) begin
        checks++;
        if (data_out !== m_data[m_idx(a)]) $display("FAIL rnd_hit_%0d: got %h expected %h", n, data_out, m_data[m_idx(a)]);
        else passed++;
      end else begin
        checks++;
        if (ext_addr !== {a[31:2], 2'b00}) $display("FAIL rnd_addr_%0d: got %h expected %h", n, ext_addr, {a[31:2], 2'b00});
        else passed++;
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        if (!w && $urandom_range(0, 3) == 0) begin
          a = rand_addr();
          drive(a, 1'b1, 1'b0, d, 1'b0, 32'h0);
          req = !m_hit(a);
          checks++;
          if (ext_re !== req) $display("FAIL rnd_redirect_%0d: got %b expected %b", n, ext_re, req);
          else passed++;
        end
      end
      xd = $urandom;
      ext_ack = 1'b1; ext_data_in = xd;
      #2;
      exp_rd = w ? 32'h0 : (m_hit(a) ? m_data[m_idx(a)] : xd);
      checks++;
      if (cache_miss_stall !== 1'b0) $display("FAIL rnd_ack_stall_%0d: got %b expected 0", n, cache_miss_stall);
      else passed++;
      if (!w) begin
        checks++;
        if (data_out !== exp_rd) $display("FAIL rnd_ack_data_%0d: got %h expected %h", n, data_out, exp_rd);
        else passed++;
      end
      if (w || !m_hit(a)) m_fill(a, w ? d : xd);
      tick();
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_read_miss_fill();
    test_write_through();
    test_conflict();
    test_region();
    test_spurious_ack();
    test_reset_mid_miss();
    test_rw_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
